// File: rtl/systolic_skew_buffer_if.sv
// Beat handshake and skewed lane bus between a producer and the skew buffer.
// The slave modport is the buffer side; the master modport is the producer/consumer side.
interface systolic_skew_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 5
);
    logic                            IN_VALID;
    logic                            IN_LAST;
    logic [SA_LENGTH*DATA_WIDTH-1:0] Inputs;
    logic                            IN_READY;
    logic [SA_LENGTH*DATA_WIDTH-1:0] Outputs;
    logic [SA_LENGTH-1:0]            OUT_VALID;
    logic                            BUSY;
    logic                            DONE;

    modport master (
        output IN_VALID, IN_LAST, Inputs,
        input  IN_READY, Outputs, OUT_VALID, BUSY, DONE
    );

    modport slave (
        input  IN_VALID, IN_LAST, Inputs,
        output IN_READY, Outputs, OUT_VALID, BUSY, DONE
    );
endinterface

// File: rtl/systolic_skew_buffer.sv
// Per-lane delay lines that skew a beat across a systolic array edge.
// Define SDS_DESKEW_EN to add a MODE port selecting deskew (reversed delays).
module systolic_skew_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int SA_LENGTH  = 5
) (
    input  logic CLK,
    input  logic SYNC_RST,
    input  logic EN,
`ifdef SDS_DESKEW_EN
    input  logic MODE,
`endif
    systolic_skew_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_e;

    localparam int CW = $clog2(SA_LENGTH + 1);
    localparam int LW = SA_LENGTH * DATA_WIDTH;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            in_ready;
    logic            accept;
    wire  [LW-1:0]   out_data;
    wire  [SA_LENGTH-1:0] out_vld;

    assign in_ready = EN && (state_q != DRAIN) && !SYNC_RST;
    assign accept   = in_ready && bus.IN_VALID;

    assign bus.IN_READY  = in_ready;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q && EN;
    assign bus.Outputs   = out_data;
    assign bus.OUT_VALID = out_vld;

    // Tile FSM: stream beats, then count down until the last lane leaves.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (EN) begin
            done_d = 1'b0;
            unique case (state_q)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (bus.IN_LAST) begin
                            if (SA_LENGTH == 1) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = DRAIN;
                                cnt_d   = CW'(SA_LENGTH - 1);
                            end
                        end else begin
                            state_d = STREAM;
                        end
                    end
                end
                DRAIN: begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SDS_DESKEW_EN
    logic mode_q, mode_d;

    // Direction is fixed for a whole tile, captured at its first beat.
    always_comb begin
        mode_d = mode_q;
        if (accept && (state_q == IDLE)) begin
            mode_d = MODE;
        end
    end
`endif

    // Control registers with reset priority over everything else.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SDS_DESKEW_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SDS_DESKEW_EN
            mode_q  <= mode_d;
`endif
        end
    end

    for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
`ifdef SDS_DESKEW_EN
        localparam int DEPTH =
            (i + 1 > SA_LENGTH - i) ? i + 1 : SA_LENGTH - i;
`else
        localparam int DEPTH = i + 1;
`endif

        logic [DATA_WIDTH-1:0] dat_q [DEPTH];
        logic [DATA_WIDTH-1:0] dat_d [DEPTH];
        logic [DEPTH-1:0]      vld_q, vld_d;

        // Shift the lane one stage; non-accepting cycles inject a bubble.
        always_comb begin
            dat_d = dat_q;
            vld_d = vld_q;
            if (EN) begin
                dat_d[0] = accept ?
                    bus.Inputs[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                vld_d[0] = accept;
                for (int j = 1; j < DEPTH; j++) begin
                    dat_d[j] = dat_q[j-1];
                    vld_d[j] = vld_q[j-1];
                end
            end
        end

        // Lane delay registers.
        always_ff @(posedge CLK) begin
            if (SYNC_RST) begin
                for (int j = 0; j < DEPTH; j++) begin
                    dat_q[j] <= '0;
                end
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

`ifdef SDS_DESKEW_EN
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] =
            mode_q ? dat_q[SA_LENGTH-1-i] : dat_q[i];
        assign out_vld[i] =
            mode_q ? vld_q[SA_LENGTH-1-i] : vld_q[i];
`else
        assign out_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
        assign out_vld[i] = vld_q[i];
`endif
    end

endmodule

// File: doc/systolic_skew_buffer.md
SYSTOLIC_SKEW_BUFFER -- requirements
Module: systolic_skew_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: bit width of one lane element.
REQ-002 The block SHALL have parameter SA_LENGTH, default 5: lane count, which equals the systolic array edge length; legal values are 1 or greater.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port SYNC_RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port EN, input, 1 bit: advance enable; when low, all state holds.
REQ-006 The block SHALL have port IN_VALID, input, 1 bit: the input beat is present.
REQ-007 The block SHALL have port IN_LAST, input, 1 bit: the input beat is the final beat of a tile; it is qualified by acceptance.
REQ-008 The block SHALL have port Inputs, input, SA_LENGTH*DATA_WIDTH bits: lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port IN_READY, output, 1 bit: the block accepts a beat this cycle.
REQ-010 The block SHALL have port Outputs, output, SA_LENGTH*DATA_WIDTH bits: skewed lane data, packed the same way as Inputs.
REQ-011 The block SHALL have port OUT_VALID, output, SA_LENGTH bits: bit i qualifies lane i of Outputs.
REQ-012 The block SHALL have port BUSY, output, 1 bit: the FSM is not in IDLE.
REQ-013 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse marking the final lane of the last beat.
REQ-014 The block SHALL have port MODE, input, 1 bit, present only with SDS_DESKEW_EN: 0 selects skew and 1 selects deskew.

Function
REQ-015 IN_READY SHALL equal EN && (state != DRAIN); a beat is accepted on a rising edge where IN_VALID && IN_READY.
REQ-016 In skew mode, lane i of a beat accepted on edge k SHALL appear on Outputs lane i with OUT_VALID[i]=1 during the cycle after edge k+i.
REQ-017 The minimum latency SHALL be one register stage, with lane 0 always registered and no combinational path from Inputs to Outputs.
REQ-018 Any cycle with EN=1 and no acceptance SHALL inject a bubble: data 0 and valid 0 enter every lane.
REQ-019 When OUT_VALID[i]=0, Outputs lane i SHALL be 0.
REQ-020 When EN=0, the delay lines, Outputs, OUT_VALID, the FSM and the drain counter SHALL hold their values, and DONE SHALL be 0.
REQ-021 The FSM SHALL have the states IDLE, STREAM and DRAIN.
REQ-022 From IDLE, an accepted beat with IN_LAST=0 SHALL move the FSM to STREAM.
REQ-023 From IDLE or STREAM, an accepted beat with IN_LAST=1 SHALL move the FSM to DRAIN.
REQ-024 In STREAM, an accepted beat with IN_LAST=0 or a bubble SHALL leave the FSM in STREAM.
REQ-025 On entry to DRAIN, the drain counter SHALL load SA_LENGTH-1.
REQ-026 In DRAIN, the counter SHALL decrement on each edge with EN=1.
REQ-027 For a last beat accepted on edge k, DONE SHALL be 1 during the cycle after edge k+SA_LENGTH-1, coincident with the final lane output.
REQ-028 The FSM SHALL re-enter IDLE on edge k+SA_LENGTH-1, so that IN_READY can be 1 in the DONE cycle.
REQ-029 When SA_LENGTH=1, the block SHALL pass through DRAIN for no cycles: DONE SHALL assert the cycle after the edge that accepts the last beat, and the FSM SHALL go directly to IDLE.
REQ-030 While in DRAIN, IN_VALID SHALL be ignored and no beat SHALL be accepted.
REQ-031 Data SHALL pass unmodified, with no arithmetic and the full DATA_WIDTH preserved.

Reset
REQ-032 While SYNC_RST=1 on an edge, the block SHALL clear all delay lines, Outputs, OUT_VALID, DONE, BUSY and the drain counter to 0, and set the state to IDLE.
REQ-033 SYNC_RST SHALL take priority over EN, IN_VALID and state transitions; a reset in DRAIN SHALL abort the tile without a DONE pulse.
REQ-034 IN_READY SHALL be 0 in any cycle in which SYNC_RST=1.

Configuration
REQ-035 With the macro SDS_DESKEW_EN defined, the block SHALL provide the MODE port.
REQ-036 With SDS_DESKEW_EN defined and MODE=1, lane i SHALL appear after edge k+(SA_LENGTH-1-i).
REQ-037 With SDS_DESKEW_EN defined, MODE SHALL be sampled only on an acceptance edge in IDLE and held until the FSM returns to IDLE; mid-tile changes SHALL be ignored.
REQ-038 Without SDS_DESKEW_EN, the block SHALL have no MODE port and SHALL operate in skew mode only, using delay lines of depth i+1 per lane.

Verification (DATA_WIDTH=8, SA_LENGTH=5)
REQ-039 Reset, then one beat of lanes {1,2,3,4,5} with IN_LAST on edge 1 -> lane i=i+1 with only OUT_VALID[i] set after edge 1+i; DONE=1 after edge 5 only; BUSY=0 after edge 5.
REQ-040 Five consecutive beats with lane i of beat j = 10*j+i, on edges 1..5, IN_LAST on beat 5 -> after edge 5, OUT_VALID=5'b11111 and lane i=10*(5-i)+i; DONE after edge 9.
REQ-041 Drop EN for 3 cycles after edge 3 in the previous scenario -> all outputs frozen; the resumed sequence is identical to the previous scenario, shifted 3 cycles; DONE after edge 12.
REQ-042 Hold IN_VALID=1 in DRAIN -> IN_READY=0 and no acceptance until DONE; IN_READY=1 in the DONE cycle.
REQ-043 SYNC_RST during DRAIN -> next cycle Outputs=0, OUT_VALID=0, BUSY=0, no DONE; a fresh beat then behaves as in the first scenario.
REQ-044 With SDS_DESKEW_EN, MODE=1, one beat on edge 1 -> lane 4 after edge 1, lane 0 after edge 5; toggling MODE mid-tile changes nothing.
